i3c_tgt_sdr_rx: RTL and testbench
=================================

I3C_TGT_SDR_RX -- requirements
Module: i3c_tgt_sdr_rx

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset: i_sdr_clk (all logic on its rising edge) and i_sdr_rst.
REQ-002 SHALL have port: i_sdr_clk, input, 1 -- system clock, at least 8x SCL frequency.
REQ-003 SHALL have port: i_sdr_rst, input, 1 -- synchronous active-high reset.
REQ-004 SHALL have port: i_target_en, input, 1 -- receiver enable; 0 ignores the bus.
REQ-005 SHALL have port: i_dyn_addr, input, 7 -- assigned dynamic address.
REQ-006 SHALL have port: i_regf_base_addr, input, 12 -- first register file write address of each frame.
REQ-007 SHALL have port: i_scl, input, 1 -- bus clock from the controller (asynchronous).
REQ-008 SHALL have port: i_sda_in, input, 1 -- sampled SDA pad (asynchronous).
REQ-009 SHALL have ports: o_sda_oe, output, 1 -- pull SDA low when 1; and o_sda_out, output, 1 -- tied 0 (open-drain).
REQ-010 SHALL have ports: o_regf_wr_en, output, 1 -- one-cycle write strobe; o_regf_wr_address, output, 12; o_regf_data, output, 8.
REQ-011 SHALL have ports: o_sdr_rx_valid, output, 1 -- one-cycle pulse per accepted byte; o_broadcast, output, 1 -- current frame addressed 7'h7E.
REQ-012 SHALL have ports: o_parity_err, output, 1 -- sticky until the next START; o_frame_done, output, 1 -- one-cycle pulse on STOP after an ACKed frame.

Function
REQ-013 SHALL pass i_scl and i_sda_in through 2-flop synchronizers, then detect edges on the synchronized values; total latency from pin to edge detection is 3 cycles.
REQ-014 SHALL detect START (including repeated START) as SDA falling while SCL is high, and STOP as SDA rising while SCL is high.
REQ-015 SHALL use FSM states IDLE, ADDR, ACK, DATA, TBIT, WAIT_STOP.
REQ-016 SHALL enter ADDR on a START from any state while i_target_en=1, clearing the bit counter and o_parity_err.
REQ-017 SHALL sample bits MSB first on each SCL rising edge.
REQ-018 ADDR SHALL collect 7 address bits plus RnW; on the 8th bit it SHALL decide:
  - address == i_dyn_addr or 7'h7E, and RnW=0 -> ACK;
  - otherwise (including any read) -> WAIT_STOP.
REQ-019 ACK SHALL assert o_sda_oe from the SCL falling edge after bit 8 until the next SCL falling edge, then go to DATA; o_broadcast SHALL be set for the frame when the address was 7'h7E.
REQ-020 DATA SHALL shift 8 bits, then go to TBIT; TBIT SHALL sample the T-bit, write the byte, and return to DATA.
REQ-021 Each accepted byte SHALL produce a 1-cycle o_regf_wr_en and o_sdr_rx_valid within 2 cycles of the T-bit SCL rising edge.
REQ-022 The write address SHALL start at i_regf_base_addr, captured at ACK, and increment per byte, wrapping 12'hFFF -> 12'h000.
REQ-023 A STOP in any state SHALL go to IDLE and clear o_sda_oe; o_frame_done SHALL pulse only if the frame was ACKed.
REQ-024 START or STOP mid-byte SHALL discard the partial byte (no write).
REQ-025 i_target_en=0 SHALL force IDLE and o_sda_oe=0 within 1 cycle.
REQ-026 The target SHALL never drive SDA outside the ACK state.

Reset
REQ-027 While i_sdr_rst=1, the FSM SHALL be IDLE, synchronizers SHALL be 1, and all outputs SHALL be 0 except o_regf_wr_address=12'h000.
REQ-028 Reset mid-frame SHALL release SDA on the same cycle; the bus is re-acquired only at the next START.

Configuration
REQ-029 With I3C_TGT_PARITY_CHECK_EN defined, the T-bit SHALL be checked as odd parity (T = ~^data); on mismatch the byte SHALL NOT be written, o_parity_err SHALL set, and the FSM SHALL go to WAIT_STOP.
REQ-030 Without I3C_TGT_PARITY_CHECK_EN, the T-bit SHALL be ignored, every byte SHALL be written, and o_parity_err SHALL be tied 0.

Structure
REQ-031 Package i3c_tgt_pkg SHALL hold the FSM state enum, BROADCAST_ADDR=7'h7E, and REGF_AW=12.
REQ-032 Synchronizers and START/STOP/edge detection SHALL live in sub-module i3c_tgt_line_sync; the FSM, shifter and address counter SHALL live in i3c_tgt_sdr_rx.

Verification
REQ-033 Test: dyn_addr=7'h30, base=12'h100; frame START, 0x60, bytes 0xA5 (T=1), 0x3C (T=1), STOP -> ACK low 1 SCL period; writes 0xA5@0x100 and 0x3C@0x101; one o_frame_done pulse.
REQ-034 Test: address 0x31 write -> no ACK, no writes, no o_frame_done.
REQ-035 Test: address 0x7E write, byte 0x07 (T=0) -> ACK, o_broadcast=1, 0x07 written.
REQ-036 Test: with the macro defined, byte 0x01 with T=1 -> no write and o_parity_err=1; without the macro -> 0x01 written.
REQ-037 Test: base=12'hFFF, two bytes -> addresses 0xFFF then 0x000.
REQ-038 Test: repeated START after 4 data bits, then 0x60 and byte 0x55 -> partial byte dropped and 0x55 written at base; i_sdr_rst asserted during ACK -> o_sda_oe=0 the next cycle.

Source files
------------

// File: rtl/i3c_tgt_pkg.sv
// ---------------------------------------------------------------------------
// i3c_tgt_pkg
// Shared definitions for the I3C target SDR write receiver:
//   REGF_AW        - register file address width
//   BROADCAST_ADDR - the I3C broadcast address (7'h7E)
//   sdr_state_e    - receive FSM states
// ---------------------------------------------------------------------------
package i3c_tgt_pkg;

  localparam int          REGF_AW        = 12;
  localparam logic [6:0]  BROADCAST_ADDR = 7'h7E;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ACK,
    DATA,
    TBIT,
    WAIT_STOP
  } sdr_state_e;

endpackage

// File: rtl/i3c_tgt_line_sync.sv
// ---------------------------------------------------------------------------
// i3c_tgt_line_sync
// Brings the asynchronous SCL/SDA pins into the system clock domain and
// turns them into single-cycle bus events.
//   clk, rst   - system clock, synchronous active-high reset
//   scl_pin    - raw SCL from the pad
//   sda_pin    - raw SDA from the pad
//   scl_rise   - pulse: SCL went 0->1
//   scl_fall   - pulse: SCL went 1->0
//   start      - pulse: SDA fell while SCL stayed high (START / Sr)
//   stop       - pulse: SDA rose while SCL stayed high (STOP)
//   sda_bit    - synchronized SDA value aligned with the event pulses
// Pin-to-event latency is 3 cycles: two synchronizer flops plus the
// registered event stage.
// ---------------------------------------------------------------------------
module i3c_tgt_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_pin,
  input  logic sda_pin,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop,
  output logic sda_bit
);

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_prev;
  logic       sda_prev;
  logic       scl_now;
  logic       sda_now;

  assign scl_now = scl_sync[1];
  assign sda_now = sda_sync[1];

  // Two-flop synchronizers plus one history flop for edge detection.
  // Everything resets to 1 so an idle (pulled-up) bus produces no edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_pin};
      sda_sync <= {sda_sync[0], sda_pin};
      scl_prev <= scl_now;
      sda_prev <= sda_now;
    end
  end

  // Registered event stage. START/STOP require SCL high on both the old and
  // new sample so an SDA change coincident with an SCL edge is never taken
  // as a bus condition.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_rise <= 1'b0;
      scl_fall <= 1'b0;
      start    <= 1'b0;
      stop     <= 1'b0;
      sda_bit  <= 1'b1;
    end else begin
      scl_rise <= scl_now & ~scl_prev;
      scl_fall <= ~scl_now & scl_prev;
      start    <= scl_now & scl_prev & sda_prev & ~sda_now;
      stop     <= scl_now & scl_prev & ~sda_prev & sda_now;
      sda_bit  <= sda_now;
    end
  end

endmodule

// File: rtl/i3c_tgt_sdr_rx.sv
// ---------------------------------------------------------------------------
// i3c_tgt_sdr_rx
// I3C target SDR private-write receiver. Recognises its dynamic address (or
// the broadcast address), ACKs the header, shifts in data bytes with their
// T-bits and writes each byte into a register file at an auto-incrementing
// address.
//   i_sdr_clk, i_sdr_rst   - system clock (>= 8x SCL), sync active-high reset
//   i_target_en            - 0 ignores the bus and releases SDA
//   i_dyn_addr             - assigned 7-bit dynamic address
//   i_regf_base_addr       - first write address of each frame
//   i_scl, i_sda_in        - asynchronous bus pins
//   o_sda_oe, o_sda_out    - open-drain SDA drive (out tied 0)
//   o_regf_wr_en/_address/_data - register file write port
//   o_sdr_rx_valid         - one-cycle pulse per accepted byte
//   o_broadcast            - current frame was addressed to 7'h7E
//   o_parity_err           - sticky T-bit error, cleared by START
//   o_frame_done           - one-cycle pulse on STOP after an ACKed frame
// Optional feature: define I3C_TGT_PARITY_CHECK_EN to check the T-bit as odd
// parity and reject bad bytes; otherwise the T-bit is ignored.
// ---------------------------------------------------------------------------
module i3c_tgt_sdr_rx
  import i3c_tgt_pkg::*;
(
  input  logic               i_sdr_clk,
  input  logic               i_sdr_rst,
  input  logic               i_target_en,
  input  logic [6:0]         i_dyn_addr,
  input  logic [REGF_AW-1:0] i_regf_base_addr,
  input  logic               i_scl,
  input  logic               i_sda_in,
  output logic               o_sda_oe,
  output logic               o_sda_out,
  output logic               o_regf_wr_en,
  output logic [REGF_AW-1:0] o_regf_wr_address,
  output logic [7:0]         o_regf_data,
  output logic               o_sdr_rx_valid,
  output logic               o_broadcast,
  output logic               o_parity_err,
  output logic               o_frame_done
);

  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;
  logic sda_bit;

  sdr_state_e         state_q;
  sdr_state_e         state_d;
  logic [2:0]         bit_cnt_q;
  logic [7:0]         shift_q;
  logic [7:0]         shift_next;
  logic               ack_drive_q;
  logic               acked_q;
  logic               bcast_q;
  logic [REGF_AW-1:0] wr_addr_q;
  logic [7:0]         data_q;
  logic               wr_en_q;
  logic               frame_done_q;
  logic               addr_match;
  logic               is_bcast;
  logic               t_ok;
  logic               sda_oe;

  i3c_tgt_line_sync u_line_sync (
    .clk      (i_sdr_clk),
    .rst      (i_sdr_rst),
    .scl_pin  (i_scl),
    .sda_pin  (i_sda_in),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start_det),
    .stop     (stop_det),
    .sda_bit  (sda_bit)
  );

  // MSB-first shift; in ADDR the 8th bit completes {address, RnW}.
  assign shift_next = {shift_q[6:0], sda_bit};
  assign is_bcast   = (shift_next[7:1] == BROADCAST_ADDR);
  assign addr_match = ((shift_next[7:1] == i_dyn_addr) || is_bcast) && !shift_next[0];

`ifdef I3C_TGT_PARITY_CHECK_EN
  logic parity_err_q;

  // T-bit is odd parity over the byte just shifted in.
  assign t_ok = (sda_bit == ~^shift_q);

  // Parity error stays set until the next START opens a new frame.
  always_ff @(posedge i_sdr_clk) begin
    if (i_sdr_rst) begin
      parity_err_q <= 1'b0;
    end else if (i_target_en && start_det) begin
      parity_err_q <= 1'b0;
    end else if (i_target_en && !stop_det && state_q == TBIT && scl_rise && !t_ok) begin
      parity_err_q <= 1'b1;
    end
  end

  assign o_parity_err = parity_err_q;
`else
  assign t_ok         = 1'b1;
  assign o_parity_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_sdr_clk) begin
    if (i_sdr_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Disable beats START, START beats STOP, and either bus
  // condition overrides whatever byte was in progress.
  always_comb begin
    state_d = state_q;
    if (!i_target_en) begin
      state_d = IDLE;
    end else if (start_det) begin
      state_d = ADDR;
    end else if (stop_det) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:      state_d = IDLE;
        ADDR:      if (scl_rise && bit_cnt_q == 3'd7) state_d = addr_match ? ACK : WAIT_STOP;
        ACK:       if (scl_fall && ack_drive_q) state_d = DATA;
        DATA:      if (scl_rise && bit_cnt_q == 3'd7) state_d = TBIT;
        TBIT:      if (scl_rise) state_d = t_ok ? DATA : WAIT_STOP;
        WAIT_STOP: state_d = WAIT_STOP;
        default:   state_d = IDLE;
      endcase
    end
  end

  // Output logic. SDA is only pulled during the ACK bit window, and reset or
  // disable release it combinationally so the bus is freed immediately.
  always_comb begin
    sda_oe = 1'b0;
    if (state_q == ACK && ack_drive_q && i_target_en && !i_sdr_rst) begin
      sda_oe = 1'b1;
    end
  end

  // Datapath: bit counter, shifter, ACK window phase, frame flags and the
  // register file write port. ack_drive_q marks the second half of ACK: the
  // first SCL fall after the header turns the drive on, the next one ends it.
  always_ff @(posedge i_sdr_clk) begin
    if (i_sdr_rst) begin
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      ack_drive_q  <= 1'b0;
      acked_q      <= 1'b0;
      bcast_q      <= 1'b0;
      wr_addr_q    <= '0;
      data_q       <= 8'h00;
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      if (wr_en_q) begin
        wr_addr_q <= wr_addr_q + REGF_AW'(1);
      end
      if (!i_target_en) begin
        bit_cnt_q   <= 3'd0;
        ack_drive_q <= 1'b0;
        acked_q     <= 1'b0;
        bcast_q     <= 1'b0;
      end else if (start_det) begin
        bit_cnt_q   <= 3'd0;
        ack_drive_q <= 1'b0;
        acked_q     <= 1'b0;
        bcast_q     <= 1'b0;
      end else if (stop_det) begin
        frame_done_q <= acked_q;
        ack_drive_q  <= 1'b0;
        acked_q      <= 1'b0;
        bcast_q      <= 1'b0;
      end else begin
        case (state_q)
          ADDR: begin
            if (scl_rise) begin
              shift_q   <= shift_next;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7 && addr_match) begin
                wr_addr_q   <= i_regf_base_addr;
                acked_q     <= 1'b1;
                bcast_q     <= is_bcast;
                ack_drive_q <= 1'b0;
              end
            end
          end
          ACK: begin
            if (scl_fall) begin
              if (!ack_drive_q) begin
                ack_drive_q <= 1'b1;
              end else begin
                ack_drive_q <= 1'b0;
                bit_cnt_q   <= 3'd0;
              end
            end
          end
          DATA: begin
            if (scl_rise) begin
              shift_q   <= shift_next;
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
          TBIT: begin
            if (scl_rise && t_ok) begin
              wr_en_q <= 1'b1;
              data_q  <= shift_q;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign o_sda_oe          = sda_oe;
  assign o_sda_out         = 1'b0;
  assign o_regf_wr_en      = wr_en_q;
  assign o_sdr_rx_valid    = wr_en_q;
  assign o_regf_wr_address = wr_addr_q;
  assign o_regf_data       = data_q;
  assign o_broadcast       = bcast_q;
  assign o_frame_done      = frame_done_q;

endmodule

// File: tb/tb_i3c_tgt_sdr_rx.sv
// ---------------------------------------------------------------------------
// tb_i3c_tgt_sdr_rx
// Bench for the I3C target SDR receiver. A bit-banged controller drives SCL
// and an open-drain SDA; expected register writes are queued as bytes are
// sent and matched against the write port as it strobes.
// ---------------------------------------------------------------------------
module tb_i3c_tgt_sdr_rx;

  localparam int Q = 8;  // SCL half period in system clocks

  logic        clk = 1'b0;
  logic        rst;
  logic        target_en;
  logic [6:0]  dyn_addr;
  logic [11:0] base_addr;
  logic        scl_drv;
  logic        sda_drv;
  logic        sda_line;

  logic        sda_oe;
  logic        sda_out;
  logic        regf_wr_en;
  logic [11:0] regf_wr_address;
  logic [7:0]  regf_data;
  logic        sdr_rx_valid;
  logic        broadcast;
  logic        parity_err;
  logic        frame_done;

  always #5 clk = ~clk;

  // Open-drain bus: either side may pull low.
  assign sda_line = sda_drv & ~sda_oe;

  i3c_tgt_sdr_rx dut (
    .i_sdr_clk         (clk),
    .i_sdr_rst         (rst),
    .i_target_en       (target_en),
    .i_dyn_addr        (dyn_addr),
    .i_regf_base_addr  (base_addr),
    .i_scl             (scl_drv),
    .i_sda_in          (sda_line),
    .o_sda_oe          (sda_oe),
    .o_sda_out         (sda_out),
    .o_regf_wr_en      (regf_wr_en),
    .o_regf_wr_address (regf_wr_address),
    .o_regf_data       (regf_data),
    .o_sdr_rx_valid    (sdr_rx_valid),
    .o_broadcast       (broadcast),
    .o_parity_err      (parity_err),
    .o_frame_done      (frame_done)
  );

  typedef struct packed {
    logic [11:0] addr;
    logic [7:0]  data;
    logic        bcast;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  int          checks    = 0;
  int          errors    = 0;
  int          wr_cnt    = 0;
  int          valid_cnt = 0;
  int          done_cnt  = 0;
  int          oe_pulses = 0;
  int          oe_len_cur  = 0;
  int          oe_len_last = 0;
  logic        oe_prev   = 1'b0;
  logic [11:0] model_addr;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Write-port monitor: pops the scoreboard on each strobe and tracks the
  // SDA drive window and frame_done pulses.
  always @(negedge clk) begin
    if (regf_wr_en) begin
      wr_cnt++;
      checkOutput("wr_expected", 32'(exp_q.size() > 0), 1);
      checkOutput("rx_valid", sdr_rx_valid, 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        checkOutput("wr_addr", regf_wr_address, mon_e.addr);
        checkOutput("wr_data", regf_data, mon_e.data);
        checkOutput("broadcast", broadcast, mon_e.bcast);
      end
    end
    if (sdr_rx_valid) valid_cnt++;
    if (frame_done) done_cnt++;
    if (sda_oe && !oe_prev) begin
      oe_pulses++;
      oe_len_cur = 1;
    end else if (sda_oe) begin
      oe_len_cur++;
    end
    if (!sda_oe && oe_prev) oe_len_last = oe_len_cur;
    oe_prev = sda_oe;
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // START from idle or repeated START from SCL low.
  task automatic sendStart();
    clks(2);
    sda_drv = 1'b1;
    clks(Q - 2);
    scl_drv = 1'b1;
    clks(Q);
    sda_drv = 1'b0;
    clks(Q);
    scl_drv = 1'b0;
  endtask

  task automatic sendBit(input logic b, output logic line);
    clks(2);
    sda_drv = b;
    clks(Q - 2);
    scl_drv = 1'b1;
    clks(Q / 2);
    line = sda_line;
    clks(Q / 2);
    scl_drv = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    logic dummy;
    for (int i = 7; i >= 0; i--) sendBit(b[i], dummy);
  endtask

  task automatic sendStop();
    clks(2);
    sda_drv = 1'b0;
    clks(Q - 2);
    scl_drv = 1'b1;
    clks(Q);
    sda_drv = 1'b1;
    clks(Q);
  endtask

  // One complete frame: header, ACK bit, up to two data bytes, STOP.
  task automatic applyStimulus(input logic [7:0] addr_byte, input int nbytes,
                               input logic [7:0] b0, input logic [7:0] b1,
                               input logic bad_t0, input logic exp_ack,
                               input logic exp_bcast);
    int         pulses0;
    int         done0;
    logic       line;
    logic       t;
    logic       blocked;
    logic [7:0] bytes [2];
    wr_t        e;
    pulses0    = oe_pulses;
    done0      = done_cnt;
    blocked    = 1'b0;
    bytes[0]   = b0;
    bytes[1]   = b1;
    model_addr = base_addr;
    sendStart();
    sendByte(addr_byte);
    sendBit(1'b1, line);
    checkOutput("ack_level", line, !exp_ack);
    for (int i = 0; i < nbytes; i++) begin
      t = ~^bytes[i];
      if (i == 0 && bad_t0) t = ~t;
      if (exp_ack && !blocked) begin
`ifdef I3C_TGT_PARITY_CHECK_EN
        if (t != ~^bytes[i]) blocked = 1'b1;
`endif
        if (!blocked) begin
          e.addr  = model_addr;
          e.data  = bytes[i];
          e.bcast = exp_bcast;
          exp_q.push_back(e);
          model_addr = model_addr + 12'd1;
        end
      end
      sendByte(bytes[i]);
      sendBit(t, line);
    end
    sendStop();
    checkOutput("ack_pulses", oe_pulses - pulses0, exp_ack);
    if (exp_ack) checkOutput("ack_len", oe_len_last, 2 * Q);
    checkOutput("frame_done", done_cnt - done0, exp_ack);
    checkOutput("wr_pending", exp_q.size(), 0);
  endtask

  initial begin
    logic line;
    int   pulses0;
    int   done0;
    int   wr0;
    rst       = 1'b1;
    target_en = 1'b1;
    dyn_addr  = 7'h30;
    base_addr = 12'h100;
    scl_drv   = 1'b1;
    sda_drv   = 1'b1;
    clks(4);
    checkOutput("rst_sda_oe", sda_oe, 0);
    checkOutput("rst_sda_out", sda_out, 0);
    checkOutput("rst_wr_en", regf_wr_en, 0);
    checkOutput("rst_wr_addr", regf_wr_address, 12'h000);
    checkOutput("rst_data", regf_data, 0);
    checkOutput("rst_valid", sdr_rx_valid, 0);
    checkOutput("rst_bcast", broadcast, 0);
    checkOutput("rst_perr", parity_err, 0);
    checkOutput("rst_done", frame_done, 0);
    rst = 1'b0;
    clks(4);

    $display("[TB] basic two-byte write to 0x30");
    applyStimulus(8'h60, 2, 8'hA5, 8'h3C, 1'b0, 1'b1, 1'b0);

    $display("[TB] foreign address 0x31");
    applyStimulus(8'h62, 2, 8'h11, 8'h22, 1'b0, 1'b0, 1'b0);

    $display("[TB] read to own address is not acked");
    applyStimulus(8'h61, 1, 8'h33, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("[TB] broadcast write");
    applyStimulus(8'hFC, 1, 8'h07, 8'h00, 1'b0, 1'b1, 1'b1);

    $display("[TB] T-bit mismatch");
    applyStimulus(8'h60, 1, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0);
`ifdef I3C_TGT_PARITY_CHECK_EN
    checkOutput("parity_err", parity_err, 1);
`else
    checkOutput("parity_err", parity_err, 0);
`endif

    $display("[TB] address wrap");
    base_addr = 12'hFFF;
    applyStimulus(8'h60, 2, 8'h5A, 8'hC3, 1'b0, 1'b1, 1'b0);
    checkOutput("parity_err_cleared", parity_err, 0);

    $display("[TB] repeated START mid-byte");
    base_addr = 12'h2A0;
    sendStart();
    sendByte(8'h60);
    sendBit(1'b1, line);
    checkOutput("sr_ack_level", line, 0);
    for (int i = 0; i < 4; i++) sendBit(1'b1, line);
    applyStimulus(8'h60, 1, 8'h55, 8'h00, 1'b0, 1'b1, 1'b0);

    $display("[TB] reset during ACK");
    done0 = done_cnt;
    wr0   = wr_cnt;
    sendStart();
    sendByte(8'h60);
    clks(2);
    sda_drv = 1'b1;
    clks(Q - 2);
    checkOutput("oe_in_ack", sda_oe, 1);
    rst = 1'b1;
    clks(1);
    checkOutput("oe_after_rst", sda_oe, 0);
    checkOutput("rst_mid_wr_addr", regf_wr_address, 12'h000);
    checkOutput("rst_mid_bcast", broadcast, 0);
    clks(2);
    rst = 1'b0;
    pulses0 = oe_pulses;
    scl_drv = 1'b1;
    clks(Q);
    scl_drv = 1'b0;
    sendByte(8'h55);
    sendBit(1'b1, line);
    sendStop();
    checkOutput("post_rst_oe", oe_pulses - pulses0, 0);
    checkOutput("post_rst_done", done_cnt - done0, 0);
    checkOutput("post_rst_writes", wr_cnt - wr0, 0);

    $display("[TB] target disabled");
    target_en = 1'b0;
    base_addr = 12'h100;
    applyStimulus(8'h60, 1, 8'h12, 8'h00, 1'b0, 1'b0, 1'b0);
    target_en = 1'b1;

    clks(8);
    checkOutput("valid_vs_wr", valid_cnt, wr_cnt);
    checkOutput("total_writes", wr_cnt,
`ifdef I3C_TGT_PARITY_CHECK_EN
                6
`else
                7
`endif
                );
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
